line_step_sequencer: RTL
========================

Name: line_step_sequencer

Overview:
- Downstream consumer of the line rasteriser. It captures the rasteriser's packed point list (x/y arrays, valid mask) on its ready pulse.
- It walks the points in index order and converts each move from the current position into step/direction pulses for the X and Y stepper drivers.
- It keeps the machine's absolute X/Y position and reports busy/done.

Parameters:
- P_MAX_LINE_LENGTH, 10, points per captured list; must match the rasteriser.
- P_X_COORD_W, 11, signed X coordinate width.
- P_Y_COORD_W, 10, signed Y coordinate width.
- P_TIMER_W, 16, width of the pulse high/low cycle counts.
- P_DIR_SETUP, 2, cycles that direction outputs are stable before the first step edge of a point.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_x_vals  in  P_MAX_LINE_LENGTH*P_X_COORD_W  packed X points; point j at [(j+1)*P_X_COORD_W-1 : j*P_X_COORD_W]
- i_y_vals  in  P_MAX_LINE_LENGTH*P_Y_COORD_W  packed Y points, same packing
- i_vals_valid  in  P_MAX_LINE_LENGTH  per-point valid mask
- i_vals_rdy  in  1  one-cycle pulse: list is complete
- i_high_cycles  in  P_TIMER_W  step-high duration; 0 is treated as 1
- i_low_cycles  in  P_TIMER_W  step-low duration; 0 is treated as 1
- i_abort  in  1  stop after the current pulse
- o_step_x, o_step_y  out  1  step pulses
- o_dir_x, o_dir_y  out  1  direction (1 = increasing coordinate)
- o_pos_x  out  P_X_COORD_W  signed absolute X position
- o_pos_y  out  P_Y_COORD_W  signed absolute Y position
- o_busy  out  1  list being executed
- o_done  out  1  one-cycle pulse at end of list or abort
- o_overrun  out  1  sticky: i_vals_rdy arrived while busy

Behaviour:
- Reset (async, i_reset_n=0): all outputs 0, including pos, dir, step, busy, done and overrun. State IDLE, point index 0.
- States: IDLE, LOAD, DIR, HI, LO, DONE.
- IDLE, i_vals_rdy=1:
  - Latch the arrays, mask, i_high_cycles and i_low_cycles.
  - Clear overrun. Go to LOAD.
  - o_busy=1 from the next cycle; latency from rdy to busy is 1 cycle.
- LOAD:
  - If index == P_MAX_LINE_LENGTH or valid[index]==0, go to DONE. The first invalid point ends the list; the mask is contiguous from bit 0.
  - Otherwise compute dx = tx - pos_x and dy = ty - pos_y, sign-extended by 1 bit.
  - If dx==0 and dy==0: index+1, stay in LOAD (1 cycle per no-op point).
  - Otherwise set o_dir_x = (dx>0) and o_dir_y = (dy>0); a zero-delta axis keeps its previous dir. Go to DIR.
- DIR: hold for P_DIR_SETUP cycles, then go to HI.
- Entering HI:
  - Assert step on each axis whose pos != target.
  - Update that pos by ±1 in the same cycle; position counts at the rising step edge.
  - Hold for high_cycles cycles, then go to LO with both steps low.
- LO: hold for low_cycles cycles. Then:
  - if pos != target on any axis, go to HI; direction is unchanged within a point, so no DIR;
  - else index+1 and go to LOAD.
- Multi-unit deltas are allowed. Each axis steps once per HI phase until it matches. The first point may be far from pos, and the list may be in descending order.
- DONE: o_done=1 for exactly 1 cycle, o_busy=0 in the same cycle, index cleared, go to IDLE.
- i_abort:
  - Sampled in LOAD, DIR or LO: go to DONE next cycle.
  - Sampled in HI: ignored until LO is reached, so a step pulse is never truncated.
  - Position reflects the steps actually issued.
- i_vals_rdy while not IDLE (including DONE): the input is ignored and o_overrun is set to 1 (sticky).
- i_vals_rdy in the same cycle as the DONE→IDLE transition is not accepted; it sets overrun.
- Position wraps two's-complement at the width limits; no saturation.
- Timers are the latched copies; changing i_high_cycles or i_low_cycles mid-list has no effect.
- Reset mid-pulse forces step low immediately and zeroes position.

Decomposition:
- Package line_step_pkg:
  - state encoding localparams (IDLE..DONE);
  - default widths;
  - helper function to extract point j from a packed vector.
- Sub-module step_phase_timer:
  - loadable down-counter, P_TIMER_W bits;
  - load value of 0 forced to 1;
  - o_expire pulse;
  - reused for the DIR, HI and LO durations.

Test Plan:
- Diagonal list (0,0),(1,1),(2,2), mask 3'b111, high=2, low=3, pos=0 → 2 step pulses per axis, dir_x=dir_y=1. Each pulse is 2 cycles high and 3 low. Final pos (2,2); o_done 1 cycle; busy falls with done.
- Descending list (5,0),(4,0),(3,0) from pos (0,0) → 5 X steps with dir 1. Then 2 X steps with dir 0, preceded by 2 DIR cycles. Final pos (3,0); Y never steps.
- Mask 10'b0000000011 with points 2..9 nonzero → only points 0 and 1 executed; done follows point 1.
- i_vals_rdy pulse while busy → o_overrun=1 and the list is unchanged. The next accepted i_vals_rdy in IDLE clears overrun.
- i_abort asserted during HI of the 2nd of 4 X steps toward target 4 → that pulse completes at full width. Done follows; final pos_x=2.
- Assert i_reset_n=0 during HI with pos (3,1) → step outputs low asynchronously; pos, busy and overrun are 0. The next i_vals_rdy starts cleanly from (0,0).

Source files
------------

// File: rtl/line_step_sequencer_pkg.sv
// Shared definitions for the line step sequencer.
//
// Contents:
//   - default parameter values, matching the upstream line rasteriser
//   - FSM state encodings (legacy-compatible localparams)
//   - point_at(): extracts point j of width w from a packed point vector
package line_step_pkg;

    localparam int unsigned DefMaxLineLength = 10;
    localparam int unsigned DefXCoordW       = 11;
    localparam int unsigned DefYCoordW       = 10;
    localparam int unsigned DefTimerW        = 16;
    localparam int unsigned DefDirSetup      = 2;

    // Sequencer FSM states
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StDir  = 3'd2;
    localparam logic [2:0] StHi   = 3'd3;
    localparam logic [2:0] StLo   = 3'd4;
    localparam logic [2:0] StDone = 3'd5;

    // Packed point vectors are zero-extended to VecMaxW before extraction, so a
    // list must satisfy length * coord width <= VecMaxW and coord width <= PointMaxW.
    localparam int unsigned VecMaxW   = 2048;
    localparam int unsigned PointMaxW = 32;

    function automatic logic [PointMaxW-1:0] point_at(input logic [VecMaxW-1:0] vec,
                                                      input int unsigned j,
                                                      input int unsigned w);
        logic [PointMaxW-1:0] mask;
        mask = (w >= PointMaxW) ? '1 : ((PointMaxW'(1) << w) - PointMaxW'(1));
        return PointMaxW'(vec >> (j * w)) & mask;
    endfunction

endpackage

// File: rtl/line_step_sequencer_step_phase_timer.sv
// Loadable down-counter that times the DIR, HI and LO phases of the sequencer.
//
// Ports:
//   i_clk       clock
//   i_reset_n   asynchronous active-low reset
//   i_load      load i_load_val this cycle (0 is loaded as 1)
//   i_load_val  phase length in cycles
//   o_expire    high during the last cycle of the loaded phase
//
// A phase loaded with N on the edge that enters it lasts exactly N cycles:
// the count reads N in the first cycle and o_expire fires when it reads 1.
module step_phase_timer
    import line_step_pkg::*;
#(
    parameter int unsigned P_TIMER_W = DefTimerW
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_load,
    input  logic [P_TIMER_W-1:0] i_load_val,
    output logic                 o_expire
);

    logic [P_TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = (i_load_val == '0) ? P_TIMER_W'(1) : i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - P_TIMER_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = (cnt_q == P_TIMER_W'(1));

endmodule

// File: rtl/line_step_sequencer.sv
// Line step sequencer: captures a packed point list from the line rasteriser and
// walks it in index order, turning each move from the current position into
// step/direction pulses for the X and Y stepper drivers.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_x_vals, i_y_vals        packed point coordinates, point j in slice j
//   i_vals_valid              per-point valid mask (contiguous from bit 0)
//   i_vals_rdy                one-cycle pulse: list complete, accepted in idle only
//   i_high_cycles/low_cycles  step high/low durations (0 treated as 1), latched
//   i_abort                   stop after the current step pulse
//   o_step_x/y, o_dir_x/y     stepper driver outputs (dir 1 = increasing)
//   o_pos_x/y                 signed absolute position, counted at the rising step edge
//   o_busy                    list being executed
//   o_done                    one-cycle pulse at end of list or abort
//   o_overrun                 sticky: a list arrived while not idle
module line_step_sequencer
    import line_step_pkg::*;
#(
    parameter int unsigned P_MAX_LINE_LENGTH = DefMaxLineLength,
    parameter int unsigned P_X_COORD_W       = DefXCoordW,
    parameter int unsigned P_Y_COORD_W       = DefYCoordW,
    parameter int unsigned P_TIMER_W         = DefTimerW,
    parameter int unsigned P_DIR_SETUP       = DefDirSetup
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset_n,
    input  logic [P_MAX_LINE_LENGTH*P_X_COORD_W-1:0]   i_x_vals,
    input  logic [P_MAX_LINE_LENGTH*P_Y_COORD_W-1:0]   i_y_vals,
    input  logic [P_MAX_LINE_LENGTH-1:0]               i_vals_valid,
    input  logic                                       i_vals_rdy,
    input  logic [P_TIMER_W-1:0]                       i_high_cycles,
    input  logic [P_TIMER_W-1:0]                       i_low_cycles,
    input  logic                                       i_abort,
    output logic                                       o_step_x,
    output logic                                       o_step_y,
    output logic                                       o_dir_x,
    output logic                                       o_dir_y,
    output logic signed [P_X_COORD_W-1:0]              o_pos_x,
    output logic signed [P_Y_COORD_W-1:0]              o_pos_y,
    output logic                                       o_busy,
    output logic                                       o_done,
    output logic                                       o_overrun
);

    localparam int unsigned IdxW = $clog2(P_MAX_LINE_LENGTH + 1);
    localparam int unsigned DxW  = P_X_COORD_W + 1;
    localparam int unsigned DyW  = P_Y_COORD_W + 1;

    logic [2:0]                   state_q, state_d;
    logic [IdxW-1:0]              idx_q, idx_d;
    logic [P_X_COORD_W-1:0]       tx_q [P_MAX_LINE_LENGTH];
    logic [P_Y_COORD_W-1:0]       ty_q [P_MAX_LINE_LENGTH];
    logic [P_MAX_LINE_LENGTH-1:0] valid_q;
    logic [P_TIMER_W-1:0]         high_q, low_q;
    logic [P_X_COORD_W-1:0]       pos_x_q, pos_x_d;
    logic [P_Y_COORD_W-1:0]       pos_y_q, pos_y_d;
    logic                         dir_x_q, dir_x_d;
    logic                         dir_y_q, dir_y_d;
    logic                         step_x_q, step_x_d;
    logic                         step_y_q, step_y_d;
    logic                         overrun_q, overrun_d;
    logic                         abort_pend_q, abort_pend_d;

    logic                         capture;
    logic                         go_hi;
    logic                         tmr_load;
    logic [P_TIMER_W-1:0]         tmr_val;
    logic                         tmr_expire;

    logic [VecMaxW-1:0]           x_vec, y_vec;
    logic [P_X_COORD_W-1:0]       cur_tx;
    logic [P_Y_COORD_W-1:0]       cur_ty;
    logic                         cur_valid;
    logic [DxW-1:0]               dx;
    logic [DyW-1:0]               dy;
    logic                         dx_up, dy_up;
    logic                         need_x, need_y;

    assign x_vec = VecMaxW'(i_x_vals);
    assign y_vec = VecMaxW'(i_y_vals);

    // Current target point. An index of P_MAX_LINE_LENGTH matches no entry, so
    // cur_valid reads 0 there and the list terminates naturally.
    always_comb begin
        cur_tx    = '0;
        cur_ty    = '0;
        cur_valid = 1'b0;
        for (int unsigned j = 0; j < P_MAX_LINE_LENGTH; j++) begin
            if (idx_q == IdxW'(j)) begin
                cur_tx    = tx_q[j];
                cur_ty    = ty_q[j];
                cur_valid = valid_q[j];
            end
        end
    end

    // One extra bit keeps the delta sign correct across the full coordinate range.
    assign dx     = {cur_tx[P_X_COORD_W-1], cur_tx} - {pos_x_q[P_X_COORD_W-1], pos_x_q};
    assign dy     = {cur_ty[P_Y_COORD_W-1], cur_ty} - {pos_y_q[P_Y_COORD_W-1], pos_y_q};
    assign dx_up  = !dx[DxW-1] && (dx != '0);
    assign dy_up  = !dy[DyW-1] && (dy != '0);
    assign need_x = (pos_x_q != cur_tx);
    assign need_y = (pos_y_q != cur_ty);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        step_x_d     = step_x_q;
        step_y_d     = step_y_q;
        overrun_d    = overrun_q;
        abort_pend_d = abort_pend_q;
        capture      = 1'b0;
        go_hi        = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = high_q;

        if (i_vals_rdy) begin
            if (state_q == StIdle) begin
                capture   = 1'b1;
                overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                abort_pend_d = 1'b0;
                if (i_vals_rdy) begin
                    state_d = StLoad;
                end
            end

            StLoad: begin
                if (i_abort || !cur_valid) begin
                    state_d = StDone;
                end else if (dx == '0 && dy == '0) begin
                    idx_d = idx_q + IdxW'(1);
                end else begin
                    // A zero-delta axis keeps its previous direction.
                    if (dx != '0) dir_x_d = dx_up;
                    if (dy != '0) dir_y_d = dy_up;
                    state_d  = StDir;
                    tmr_load = 1'b1;
                    tmr_val  = P_TIMER_W'(P_DIR_SETUP);
                end
            end

            StDir: begin
                if (i_abort) begin
                    state_d = StDone;
                end else if (tmr_expire) begin
                    go_hi = 1'b1;
                end
            end

            StHi: begin
                // Remember an abort seen mid-pulse; it is acted on once LO starts.
                if (i_abort) begin
                    abort_pend_d = 1'b1;
                end
                if (tmr_expire) begin
                    state_d  = StLo;
                    step_x_d = 1'b0;
                    step_y_d = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = low_q;
                end
            end

            StLo: begin
                if (i_abort || abort_pend_q) begin
                    state_d = StDone;
                end else if (tmr_expire) begin
                    if (need_x || need_y) begin
                        go_hi = 1'b1;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StLoad;
                    end
                end
            end

            StDone: begin
                idx_d        = '0;
                abort_pend_d = 1'b0;
                state_d      = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Rising step edge: each axis still short of its target steps once and
        // its position moves with the edge.
        if (go_hi) begin
            state_d  = StHi;
            tmr_load = 1'b1;
            tmr_val  = high_q;
            step_x_d = need_x;
            step_y_d = need_y;
            if (need_x) begin
                pos_x_d = dir_x_q ? pos_x_q + P_X_COORD_W'(1) : pos_x_q - P_X_COORD_W'(1);
            end
            if (need_y) begin
                pos_y_d = dir_y_q ? pos_y_q + P_Y_COORD_W'(1) : pos_y_q - P_Y_COORD_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            dir_x_q      <= 1'b0;
            dir_y_q      <= 1'b0;
            step_x_q     <= 1'b0;
            step_y_q     <= 1'b0;
            overrun_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            step_x_q     <= step_x_d;
            step_y_q     <= step_y_d;
            overrun_q    <= overrun_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // List capture: points, mask and the pulse timing used for the whole list.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned j = 0; j < P_MAX_LINE_LENGTH; j++) begin
                tx_q[j] <= '0;
                ty_q[j] <= '0;
            end
            valid_q <= '0;
            high_q  <= '0;
            low_q   <= '0;
        end else if (capture) begin
            for (int unsigned j = 0; j < P_MAX_LINE_LENGTH; j++) begin
                tx_q[j] <= P_X_COORD_W'(point_at(x_vec, j, P_X_COORD_W));
                ty_q[j] <= P_Y_COORD_W'(point_at(y_vec, j, P_Y_COORD_W));
            end
            valid_q <= i_vals_valid;
            high_q  <= i_high_cycles;
            low_q   <= i_low_cycles;
        end
    end

    step_phase_timer #(
        .P_TIMER_W (P_TIMER_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_expire   (tmr_expire)
    );

    assign o_step_x  = step_x_q;
    assign o_step_y  = step_y_q;
    assign o_dir_x   = dir_x_q;
    assign o_dir_y   = dir_y_q;
    assign o_pos_x   = pos_x_q;
    assign o_pos_y   = pos_y_q;
    assign o_busy    = (state_q != StIdle) && (state_q != StDone);
    assign o_done    = (state_q == StDone);
    assign o_overrun = overrun_q;

endmodule
